// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - NCH-channel programmable down-counter timer with prescaler and IRQs
// Each channel runs an IDLE/CNT/INT FSM; a register write always beats the same-cycle FSM update.
module timer_multi #(
  parameter int NCH = 2,
  parameter int CW  = 32,
  parameter int PSW = 8,
  localparam int AW = ((NCH > 1) ? $clog2(NCH) : 0) + 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [AW-1:0]  addr,
  input  logic           we,
  input  logic [31:0]    din,
  output logic [31:0]    dout,
  output logic           irq,
  output logic [NCH-1:0] irq_vec,
  output logic [NCH-1:0] tout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CNT  = 2'd1;
  localparam logic [1:0] S_INT  = 2'd2;

  logic [AW-1:0]  chsel;
  logic [1:0]     rsel;
  logic           ch_ok;

  logic [NCH-1:0] en, im, pend, tout_q, tick;
  logic [NCH-1:0] wr_ctrl, wr_preset, wr_psc;
  logic [1:0]     mode     [NCH];
  logic [1:0]     state    [NCH];
  logic [CW-1:0]  preset   [NCH];
  logic [CW-1:0]  count    [NCH];
  logic [PSW-1:0] prescale [NCH];
  logic [PSW-1:0] psc      [NCH];

  assign chsel = addr >> 2;
  assign rsel  = addr[1:0];
  assign ch_ok = (chsel < AW'(NCH));

  always_comb begin
    wr_ctrl   = '0;
    wr_preset = '0;
    wr_psc    = '0;
    tick      = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_ctrl[i]   = we && ch_ok && (chsel == AW'(i)) && (rsel == 2'd0);
      wr_preset[i] = we && ch_ok && (chsel == AW'(i)) && (rsel == 2'd1);
      wr_psc[i]    = we && ch_ok && (chsel == AW'(i)) && (rsel == 2'd3);
      tick[i]      = (psc[i] == prescale[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en     <= '0;
      im     <= '0;
      pend   <= '0;
      tout_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode[i]     <= 2'b00;
        state[i]    <= S_IDLE;
        preset[i]   <= '0;
        count[i]    <= '0;
        prescale[i] <= '0;
        psc[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_preset[i]) preset[i] <= din[CW-1:0];
        if (wr_psc[i])    prescale[i] <= din[PSW-1:0];

        if (wr_ctrl[i]) begin
          en[i]    <= din[0];
          mode[i]  <= din[2:1];
          im[i]    <= din[3];
          pend[i]  <= 1'b0;
          state[i] <= S_IDLE;
        end else begin
          case (state[i])
            S_IDLE: begin
              if (en[i]) begin
                count[i] <= preset[i];
                state[i] <= S_CNT;
              end
            end
            S_CNT: begin
              if (!en[i]) begin
                state[i] <= S_IDLE;
              end else if (count[i] == '0) begin
                state[i] <= S_INT;
                pend[i]  <= 1'b1;
              end else if (tick[i]) begin
                count[i] <= count[i] - 1'b1;
              end
            end
            S_INT: begin
              // Mode 2'b11 is treated as one-shot.
              if (mode[i] == 2'b01 || mode[i] == 2'b10) begin
                count[i] <= preset[i];
                state[i] <= S_CNT;
                if (mode[i] == 2'b10) tout_q[i] <= ~tout_q[i];
              end else begin
                en[i]    <= 1'b0;
                state[i] <= S_IDLE;
              end
            end
            default: state[i] <= S_IDLE;
          endcase
        end

        if (wr_ctrl[i] || wr_psc[i] || state[i] != S_CNT) psc[i] <= '0;
        else if (tick[i]) psc[i] <= '0;
        else psc[i] <= psc[i] + 1'b1;
      end
    end
  end

  always_comb begin
    dout = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_ok && chsel == AW'(i)) begin
        case (rsel)
          2'd0: dout = {27'b0, pend[i], im[i], mode[i], en[i]};
          2'd1: dout[CW-1:0] = preset[i];
          2'd2: dout[CW-1:0] = count[i];
          default: dout[PSW-1:0] = prescale[i];
        endcase
      end
    end
  end

  assign irq_vec = pend & im;
  assign irq     = |irq_vec;
  assign tout    = tout_q;

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - scoreboard bench for timer_multi (NCH=3)
// Stimulus queues expected values per cycle; the monitor compares them at the falling edge.
module tb_timer_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = '0;
  logic        we = 1'b0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;
  logic [2:0]  irq_vec;
  logic [2:0]  tout;

  timer_multi #(.NCH(3), .CW(32), .PSW(8)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din),
    .dout(dout), .irq(irq), .irq_vec(irq_vec), .tout(tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  int t1cnt[8]  = '{0, 5, 4, 3, 2, 1, 0, 0};
  int t2cnt[12] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0, 3};
  int t3cnt[6]  = '{2, 2, 1, 1, 0, 0};

  task automatic cyc(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [3:0] a, logic [31:0] d);
    addr = a; din = d; we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic cmp(logic [31:0] act, logic [31:0] e, string nm);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, e);
    end
  endtask

  task automatic chk(int kind, logic [31:0] e, string nm);
    item_t it;
    it.kind = kind; it.exp = e; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic chkd(logic [3:0] a, logic [31:0] e, string nm);
    addr = a;
    chk(0, e, nm);
  endtask

  always @(negedge clk) begin
    item_t it;
    logic [31:0] act;
    while (sb.size() > 0) begin
      it = sb.pop_front();
      case (it.kind)
        0:       act = dout;
        1:       act = {31'b0, irq};
        2:       act = {29'b0, irq_vec};
        default: act = {29'b0, tout};
      endcase
      cmp(act, it.exp, it.name);
    end
  end

  initial begin
    // reset state
    cyc(2);
    addr = 4'h2;
    #1;
    cmp({31'b0, irq}, 0, "rst irq direct");
    cmp(dout, 0, "rst count direct");
    chkd(4'h2, 0, "rst count"); chk(1, 0, "rst irq");
    cyc(1);
    rst = 1'b0;
    chkd(4'h0, 0, "rst ctrl"); chk(2, 0, "rst irq_vec"); chk(3, 0, "rst tout");
    cyc(1);

    // one-shot, PRESET 5
    wr(4'h1, 5); wr(4'h0, 32'h9);
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) chkd(4'h2, t1cnt[k], $sformatf("t1 count k=%0d", k));
      else       chkd(4'h0, 32'h18, "t1 ctrl after oneshot");
      chk(1, 32'(k >= 7), $sformatf("t1 irq k=%0d", k));
      cyc(1);
    end
    cmp({31'b0, irq}, 1, "t1 irq expired wait");
    wr(4'h0, 0);
    chk(1, 0, "t1 irq clear"); chkd(4'h0, 0, "t1 ctrl clear");
    cyc(1);

    // auto-reload, PRESET 3, IM=1
    wr(4'h1, 3); wr(4'h0, 32'hB);
    for (int k = 0; k <= 12; k++) begin
      if (k < 12) chkd(4'h2, t2cnt[k], $sformatf("t2 count k=%0d", k));
      else        chkd(4'h0, 32'h1B, "t2 ctrl pend");
      chk(1, 32'(k >= 5), $sformatf("t2 irq k=%0d", k));
      cyc(1);
    end
    // auto-reload with IM=0
    wr(4'h0, 32'h3);
    for (int k = 0; k <= 7; k++) begin
      chkd(4'h0, (k >= 5) ? 32'h13 : 32'h03, $sformatf("t2m ctrl k=%0d", k));
      chk(2, 0, $sformatf("t2m irq_vec k=%0d", k));
      cyc(1);
    end
    wr(4'h0, 0);

    // square wave, PRESET 2, PRESCALE 1
    wr(4'h1, 2); wr(4'h3, 1); wr(4'h0, 32'h5);
    for (int k = 0; k <= 19; k++) begin
      chk(3, 32'((int'(k >= 7) + int'(k >= 13) + int'(k >= 19)) % 2), $sformatf("t3 tout k=%0d", k));
      if (k >= 1) chkd(4'h2, t3cnt[(k - 1) % 6], $sformatf("t3 count k=%0d", k));
      cyc(1);
    end
    wr(4'h0, 0); wr(4'h3, 0);

    // two independent channels: ch1 PRESET 9 at E0, ch0 PRESET 4 at E1
    wr(4'h5, 9); wr(4'h1, 4); wr(4'h4, 32'h9);
    for (int k = 0; k <= 12; k++) begin
      chk(2, (k >= 11) ? 32'h3 : (k >= 7) ? 32'h1 : 32'h0, $sformatf("t4 irq_vec k=%0d", k));
      if (k >= 1) chkd(4'h6, (k <= 10) ? 32'(10 - k) : 32'h0, $sformatf("t4 ch1 count k=%0d", k));
      if (k == 0) wr(4'h0, 32'h9);
      else        cyc(1);
    end
    wr(4'h0, 0); wr(4'h4, 0);

    // CTRL rewrite on the expiry edge
    wr(4'h1, 2); wr(4'h0, 32'h9);
    cyc(3);
    wr(4'h0, 32'h8);
    chk(1, 0, "t5 irq at expiry"); chkd(4'h0, 32'h8, "t5 ctrl at expiry");
    cyc(1);
    chk(1, 0, "t5 irq after"); chkd(4'h0, 32'h8, "t5 ctrl after");
    cyc(1);

    // async reset mid-count
    wr(4'h1, 5); wr(4'h0, 32'h9);
    cyc(2);
    rst = 1'b1;
    chkd(4'h2, 0, "t6 count in rst"); chk(1, 0, "t6 irq in rst"); chk(3, 0, "t6 tout in rst");
    cyc(1);
    rst = 1'b0;
    chkd(4'h0, 0, "t6 ctrl"); cyc(1);
    chkd(4'h1, 0, "t6 preset"); cyc(1);
    chkd(4'h3, 0, "t6 prescale"); cyc(1);
    for (int k = 0; k < 8; k++) begin
      chk(1, 0, $sformatf("t6 irq k=%0d", k));
      cyc(1);
    end

    // channel index beyond NCH
    wr(4'hD, 7); wr(4'hC, 32'h9);
    chkd(4'hD, 0, "t7 ch3 preset"); cyc(1);
    chkd(4'hC, 0, "t7 ch3 ctrl"); cyc(1);
    chkd(4'h1, 0, "t7 ch0 preset"); cyc(1);
    chkd(4'h0, 0, "t7 ch0 ctrl"); cyc(1);
    chk(2, 0, "t7 irq_vec"); cyc(3);
    chk(2, 0, "t7 irq_vec later"); cyc(1);

    // PRESET 0 on ch2
    wr(4'h8, 32'h9);
    for (int k = 0; k <= 2; k++) begin
      chk(2, (k >= 2) ? 32'h4 : 32'h0, $sformatf("t8 irq_vec k=%0d", k));
      chkd(4'hA, 0, $sformatf("t8 count k=%0d", k));
      cyc(1);
    end

    cyc(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
